mul_acc_ctrl: RTL and testbench
===============================

# mul_acc_ctrl

Operand sequencer and product accumulator wrapped around the 4x4 sequential multiplier (`mul4x4`). It accepts a stream of 4-bit operand pairs over a valid/ready handshake and issues one multiplication per pair. It sums the 8-bit products into an accumulator and, on the pair flagged last, presents the dot-product result on an output valid/ready port. It sits directly upstream of the multiplier, driving START/A/B, and directly downstream of it, consuming DONE/Y.

## Interface
Parameters:
- ACC_W, 12: accumulator and result width. Must be at least 8.
- TIMEOUT, 15: watchdog limit, in cycles spent waiting for MUL_DONE. Only used with MUL_ACC_TIMEOUT_EN.

Ports:
- CLK  in  1  clock. All state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  block can accept a pair.
- IN_A, IN_B  in  4  operands.
- IN_LAST  in  1  pair is the final term of the current dot product.
- MUL_START  out  1  one-cycle start pulse to the multiplier.
- MUL_A, MUL_B  out  4  multiplier operands.
- MUL_DONE  in  1  multiplier done pulse.
- MUL_Y  in  8  multiplier product.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- OUT_SUM  out  ACC_W  accumulated sum.
- OUT_OVF  out  1  sticky flag: the accumulator wrapped during this dot product.
- OUT_ERR  out  1  sticky flag: a multiplier timeout occurred during this dot product.

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT.
- **IDLE:**
  - IN_READY=1.
  - On IN_VALID&IN_READY: register IN_A→MUL_A, IN_B→MUL_B and IN_LAST→last_q; go to ISSUE.
- **ISSUE:**
  - MUL_START=1 for exactly this cycle; go to WAIT.
- **WAIT:**
  - MUL_A and MUL_B are held stable from capture until MUL_DONE.
  - On MUL_DONE: acc ← acc + MUL_Y, truncated to ACC_W bits, with the adder's carry-out ORed into the OVF flag.
  - Then go to OUT if last_q is set, otherwise go to IDLE.
- **OUT:**
  - OUT_VALID=1. OUT_SUM, OUT_OVF and OUT_ERR are held stable until OUT_READY.
  - On OUT_VALID&OUT_READY: clear acc, OVF and ERR; go to IDLE.
- MUL_DONE is ignored in every state except WAIT.
- IN_VALID is ignored unless the state is IDLE.
- OUT_SUM always reflects the accumulator register.

## Timing
- Reset values, applied asynchronously and immediately, including mid-operation:
  - state=IDLE, so IN_READY=1.
  - MUL_START=0, MUL_A=MUL_B=0.
  - OUT_VALID=0, OUT_SUM=0, OUT_OVF=0, OUT_ERR=0.
- Multiplier contract:
  - START is sampled on the edge at the end of the ISSUE cycle.
  - MUL_DONE is a single-cycle pulse, nominally in the 4th cycle after the ISSUE cycle.
  - The block must work for any latency ≥ 1.
- Per-term timing, with the handshake in cycle 0:
  - ISSUE in cycle 1, DONE in cycle 5, accumulate on edge 5.
  - Cycle 6: IN_READY=1 (non-last term) or OUT_VALID=1 (last term).
  - Throughput: 6 cycles per term.
- OUT_VALID remains high until the handshake. IN_READY stays 0 in ISSUE, WAIT and OUT.
- A dot product with a single term is legal.
- Accumulation and a handshake never coincide, because they occur in disjoint states.

## Configuration
- Macro: MUL_ACC_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT. If TIMEOUT cycles elapse without MUL_DONE, the term contributes 0 and ERR is set.
  - The FSM then transitions as if MUL_DONE had arrived.
  - The counter clears on entry to WAIT.
- When undefined:
  - No counter is built, WAIT waits indefinitely, and OUT_ERR is tied to 0.

## Test plan
- Single pair 1*1 with IN_LAST=1 → MUL_START pulses in cycle 1; OUT_VALID=1 in cycle 6 with OUT_SUM=1 and OUT_OVF=0.
- Pairs (1,5), (2,6), (3,7), (4,8), last on the 4th → OUT_SUM=70; IN_READY is low during each term and high in the cycle after each non-last DONE.
- Overflow with ACC_W=12:
  - 19 pairs of 15*15 → OUT_SUM=179 (4275 mod 4096) and OUT_OVF=1.
  - 16 pairs → OUT_SUM=3600 and OUT_OVF=0.
- Output back-pressure: hold OUT_READY=0 for 3 cycles → OUT_VALID, OUT_SUM and the flags stay stable and IN_READY stays 0. After the handshake, run 2*3 as a last pair → OUT_SUM=6, not accumulated onto the previous result.
- Reset mid-operation: assert RST_N=0 during WAIT → all outputs take their reset values immediately and a subsequent late MUL_DONE is ignored. A following 10*10 last pair → OUT_SUM=100.
- Timeout, with MUL_ACC_TIMEOUT_EN defined and TIMEOUT=15: the bench model suppresses DONE for a single last pair → OUT_VALID after 15 WAIT cycles with OUT_SUM=0 and OUT_ERR=1. Without the macro, OUT_VALID stays 0 for 100 cycles.

Source files
------------

// File: rtl/mul_acc_ctrl.sv
// Operand sequencer and dot-product accumulator around the 4x4 sequential multiplier.
// Optional multiplier watchdog is built when MUL_ACC_TIMEOUT_EN is defined.
module mul_acc_ctrl #(
    parameter int ACC_W   = 12,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic             mul_start,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic             mul_done,
    input  logic [7:0]       mul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_q;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic               timeout_hit;
    logic [ACC_W:0]     acc_sum;

    if (ACC_W < 8 || TIMEOUT < 1) begin : g_cfg_check
        $error("mul_acc_ctrl: ACC_W must be >= 8 and TIMEOUT >= 1");
    end

    // Returns {carry, sum}; the carry feeds the sticky wrap flag.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       y);
        return {1'b0, a} + (ACC_W+1)'(y);
    endfunction

    assign acc_sum = acc_add(acc, mul_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mul_done || timeout_hit) state_nxt = last_q ? S_OUT : S_IDLE;
            S_OUT:   if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        mul_start = (state == S_ISSUE);
        out_valid = (state == S_OUT);
    end

    // Operand capture: operands stay put until the next accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a  <= '0;
            mul_b  <= '0;
            last_q <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            mul_a  <= in_a;
            mul_b  <= in_b;
            last_q <= in_last;
        end
    end

    // Accumulator: only WAIT adds, only the OUT handshake clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (state == S_WAIT && mul_done) begin
            acc <= acc_sum[ACC_W-1:0];
            ovf <= ovf | acc_sum[ACC_W];
        end else if (state == S_OUT && out_ready) begin
            acc <= '0;
            ovf <= 1'b0;
        end
    end

    assign out_sum = acc;
    assign out_ovf = ovf;

`ifdef MUL_ACC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err;

    // Watchdog restarts in ISSUE so every WAIT starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT && !mul_done) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == S_WAIT) && !mul_done &&
                         (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end else if (state == S_OUT && out_ready) begin
            err <= 1'b0;
        end
    end

    assign out_err = err;
`else
    assign timeout_hit = 1'b0;
    assign out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mul_acc_ctrl.sv
// Directed bench for mul_acc_ctrl with a 4-cycle behavioural multiplier model.
module tb_mul_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a, in_b;
    logic        in_last;
    logic        mul_start;
    logic [3:0]  mul_a, mul_b;
    logic        mul_done;
    logic [7:0]  mul_y;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic        out_ovf;
    logic        out_err;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] y_q = 8'd0;
    int         lat = 0;
    logic       suppress = 1'b0;

    mul_acc_ctrl #(.ACC_W(12), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_y(mul_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Multiplier model: DONE in the 4th cycle after the ISSUE cycle, ignores DUT reset.
    always @(posedge clk) begin
        if (mul_start) begin
            y_q <= {4'b0, mul_a} * {4'b0, mul_b};
            lat <= 4;
        end else if (lat > 0) begin
            lat <= lat - 1;
        end
    end
    assign mul_done = (lat == 1) && !suppress;
    assign mul_y    = y_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic out_hs();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_vld", out_valid, 0);
        chk("hs_rdy", in_ready, 1);
    endtask

    // One term from handshake (cycle 0) through cycle 6.
    task automatic term(input logic [3:0] a, input logic [3:0] b, input logic last, input bit tmg);
        chk("term_rdy", in_ready, 1);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        step();
        in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; in_last = 1'b0;
        if (tmg) begin
            chk("start_c1", mul_start, 1);
            chk("mul_a_c1", mul_a, a);
            chk("mul_b_c1", mul_b, b);
        end
        for (int c = 2; c <= 5; c++) begin
            step();
            if (tmg) begin
                chk("busy_rdy", in_ready, 0);
                chk("hold_a", mul_a, a);
                if (c == 2) chk("start_c2", mul_start, 0);
                if (c == 5) chk("vld_c5", out_valid, 0);
            end
        end
        step();
        if (last) chk("out_vld", out_valid, 1);
        else      chk("next_rdy", in_ready, 1);
    endtask

    initial begin
        int  cyc;
        bit  seen;

        rst_n = 1'b0; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
        in_last = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_rdy", in_ready, 1);
        chk("rst_start", mul_start, 0);
        chk("rst_a", mul_a, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_err", out_err, 0);
        rst_n = 1'b1;
        step();

        // single 1*1
        term(4'd1, 4'd1, 1'b1, 1'b1);
        chk("t1_sum", out_sum, 1);
        chk("t1_ovf", out_ovf, 0);
        chk("t1_rdy", in_ready, 0);
        out_hs();

        // 1*5+2*6+3*7+4*8 = 70
        term(4'd1, 4'd5, 1'b0, 1'b1);
        term(4'd2, 4'd6, 1'b0, 1'b1);
        term(4'd3, 4'd7, 1'b0, 1'b1);
        term(4'd4, 4'd8, 1'b1, 1'b1);
        chk("t2_sum", out_sum, 70);
        chk("t2_ovf", out_ovf, 0);
        out_hs();

        // 19 * 225 = 4275 -> 179 with wrap
        for (int i = 0; i < 19; i++) term(4'd15, 4'd15, (i == 18), 1'b0);
        chk("t3_sum", out_sum, 179);
        chk("t3_ovf", out_ovf, 1);
        out_hs();

        // 16 * 225 = 3600, no wrap; then back-pressure
        for (int i = 0; i < 16; i++) term(4'd15, 4'd15, (i == 15), 1'b0);
        chk("t4_sum", out_sum, 3600);
        chk("t4_ovf", out_ovf, 0);
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_vld", out_valid, 1);
            chk("bp_sum", out_sum, 3600);
            chk("bp_ovf", out_ovf, 0);
            chk("bp_err", out_err, 0);
            chk("bp_rdy", in_ready, 0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_hs();
        chk("bp_clr", out_sum, 0);
        term(4'd2, 4'd3, 1'b1, 1'b0);
        chk("t5_sum", out_sum, 6);
        out_hs();

        // reset during WAIT, late DONE must be ignored
        term(4'd3, 4'd3, 1'b0, 1'b0);
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd7; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        step(); step();
        chk("pre_sum", out_sum, 9);
        chk("pre_rdy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mr_rdy", in_ready, 1);
        chk("mr_start", mul_start, 0);
        chk("mr_a", mul_a, 0);
        chk("mr_b", mul_b, 0);
        chk("mr_vld", out_valid, 0);
        chk("mr_sum", out_sum, 0);
        chk("mr_ovf", out_ovf, 0);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("late_vld", out_valid, 0);
        chk("late_sum", out_sum, 0);
        chk("late_rdy", in_ready, 1);
        term(4'd10, 4'd10, 1'b1, 1'b0);
        chk("t6_sum", out_sum, 100);
        out_hs();

        // DONE suppressed
        suppress = 1'b1;
        in_valid = 1'b1; in_a = 4'd5; in_b = 4'd5; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
`ifdef MUL_ACC_TIMEOUT_EN
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            step();
            cyc++;
        end
        chk("to_cyc", cyc, 17);
        chk("to_vld", out_valid, 1);
        chk("to_sum", out_sum, 0);
        chk("to_err", out_err, 1);
        out_hs();
        chk("to_errclr", out_err, 0);
        suppress = 1'b0;
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            seen |= out_valid;
        end
        chk("nto_vld", seen, 0);
        chk("nto_err", out_err, 0);
        suppress = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
`endif
        term(4'd4, 4'd4, 1'b1, 1'b0);
        chk("end_sum", out_sum, 16);
        chk("end_err", out_err, 0);
        out_hs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
